id_ex_stage: RTL
================

# id_ex_stage

Parametrised ID/EX pipeline register with valid tracking, stall/flush control, load-use hazard detection and debug event counters. Sits between the decode and execute stages and replaces the plain ID/EX latch: it carries operands, immediate, register addresses, PC+4 and a generic control bundle into EX. It also reports to the hazard/debug units when EX holds a load whose destination collides with the decoding instruction.

## Interface
Parameters:
- NB, 32, datapath width (operands, immediate, PC+4)
- NB_OPCODE, 6, opcode width
- NB_FCODE, 6, funct code width
- NB_REG, 5, register address width
- NB_CTRL, 8, control bundle width
- CTRL_MEM_READ_BIT, 1, index of the mem-read flag inside the control bundle
- NB_CNT, 16, width of each event counter

Ports:
- i_clk  in  1  pipeline clock; the register updates on the falling edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_step  in  1  advance enable; 0 freezes every register and counter
- i_stall  in  1  hold current ID/EX contents
- i_flush  in  1  load a bubble instead of the incoming instruction
- i_clear_counters  in  1  synchronous clear of both counters
- i_valid  in  1  incoming instruction is real
- i_instruction_funct_code  in  NB_FCODE  funct code
- i_instruction_op_code  in  NB_OPCODE  opcode
- i_alu_src  in  1  0 data_b, 1 immediate
- i_ctrl  in  NB_CTRL  control bundle for EX/MEM/WB
- i_rs, i_rt, i_rd  in  NB_REG each  register addresses
- i_data_a, i_data_b, i_extension_result, i_pc_plus4  in  NB each  operands, immediate, PC+4
- o_* (one per data input above, plus o_valid)  out  same widths  registered copies
- o_load_use_hazard  out  1  combinational hazard flag
- o_stall_count, o_bubble_count  out  NB_CNT each  event counters

## Operation
- All outputs reset to 0 asynchronously while i_reset_n=0. This includes o_valid, the counters and o_load_use_hazard.
- Per falling edge, priority is: reset > !i_step > i_flush > i_stall > load.
- Behaviour by case:
  - !i_step: everything holds, counters included. i_clear_counters is ignored.
  - i_flush: bubble. Every registered output goes to 0, so o_valid=0 and o_ctrl=0. o_bubble_count increments.
  - i_stall (no flush): all registered outputs hold. o_stall_count increments.
  - Otherwise: every o_* takes the matching i_*, and o_valid takes i_valid.
- When flush and stall are asserted together, flush wins. Only o_bubble_count increments.
- Counters saturate at 2^NB_CNT-1 and never wrap.
- i_clear_counters (while i_step=1) zeroes both counters on that edge and overrides any increment in the same edge. The pipeline action of that edge still occurs.
- o_load_use_hazard = o_valid & o_ctrl[CTRL_MEM_READ_BIT] & (o_rt != 0) & ((o_rt == i_rs) | (o_rt == i_rt)).
  - Purely combinational from the registered state and the current decode addresses.
  - This block never acts on the flag itself; the hazard unit drives i_stall/i_flush.

## Timing
- Latency is 1 falling edge from the inputs to the o_* outputs.
- o_load_use_hazard has zero latency: it changes immediately when i_rs/i_rt change.
- Counters update on the same edge as the event. Their value is visible after that edge.
- Reset may assert mid-operation at any time. Outputs clear immediately, without waiting for a clock edge. The first load happens on the first falling edge with i_reset_n=1 and i_step=1.
- Inputs must be stable around the falling edge. Upstream stages drive on the rising edge.

## Test plan
- Reset/load: hold i_reset_n=0, then release. Drive i_step=1, i_valid=1, i_data_a=0x12345678, i_rd=7 for one falling edge -> o_data_a=0x12345678, o_rd=7, o_valid=1. Then reassert reset mid-cycle -> all outputs 0 immediately.
- Step gating: with i_step=0, change every input and pulse i_flush and i_clear_counters -> no output changes and counters unchanged.
- Stall/flush priority:
  - Load opcode 0x23, then apply i_stall=1 for 3 edges -> outputs hold 0x23, o_stall_count=3.
  - Then apply i_stall=1 with i_flush=1 -> all outputs 0, o_bubble_count=1, o_stall_count still 3.
- Load-use hazard:
  - Registered o_valid=1, mem-read bit=1, o_rt=5. Drive i_rs=5 -> o_load_use_hazard=1 with no clock.
  - i_rs=6 and i_rt=6 -> 0.
  - o_rt=0 with i_rs=0 -> 0.
  - After a flush -> 0.
- Counter saturation/clear:
  - With NB_CNT=4, stall 20 edges -> o_stall_count stays at 15.
  - i_clear_counters with i_stall=1 on the same edge -> count 0.
- Parametrisation: instantiate NB=16, NB_CTRL=4 and repeat the load case with 0xBEEF -> o_data_b=0xBEEF, all widths correct.

Source files
------------

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register placed between decode and execute. It carries the
// decoded operands, immediate, register addresses, PC+4 and a generic control
// bundle into EX, and tracks whether the instruction in EX is real.
//
// The stage also flags a load-use hazard when EX holds a load whose
// destination (rt) matches a source of the instruction now in decode. It
// keeps two saturating debug counters: stall events and bubble events.
//
// Ports
//   i_clk                  pipeline clock (register updates on falling edge)
//   i_reset_n              asynchronous, active-low reset
//   i_step                 advance enable; 0 freezes registers and counters
//   i_stall                hold current ID/EX contents
//   i_flush                load a bubble instead of the incoming instruction
//   i_clear_counters       synchronous clear of both event counters
//   i_valid                incoming instruction is real
//   i_instruction_*        funct code / opcode of the decoding instruction
//   i_alu_src              0 selects data_b, 1 selects the immediate
//   i_ctrl                 control bundle for EX/MEM/WB
//   i_rs, i_rt, i_rd       register addresses
//   i_data_a, i_data_b     operands
//   i_extension_result     sign/zero extended immediate
//   i_pc_plus4             PC+4 of the decoding instruction
//   o_*                    registered copies of the inputs above, plus o_valid
//   o_load_use_hazard      combinational load-use hazard flag
//   o_stall_count          saturating count of stall edges
//   o_bubble_count         saturating count of flush (bubble) edges
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int NB                = 32,
    parameter int NB_OPCODE         = 6,
    parameter int NB_FCODE          = 6,
    parameter int NB_REG            = 5,
    parameter int NB_CTRL           = 8,
    parameter int CTRL_MEM_READ_BIT = 1,
    parameter int NB_CNT            = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_step,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic                 i_clear_counters,
    input  logic                 i_valid,
    input  logic [NB_FCODE-1:0]  i_instruction_funct_code,
    input  logic [NB_OPCODE-1:0] i_instruction_op_code,
    input  logic                 i_alu_src,
    input  logic [NB_CTRL-1:0]   i_ctrl,
    input  logic [NB_REG-1:0]    i_rs,
    input  logic [NB_REG-1:0]    i_rt,
    input  logic [NB_REG-1:0]    i_rd,
    input  logic [NB-1:0]        i_data_a,
    input  logic [NB-1:0]        i_data_b,
    input  logic [NB-1:0]        i_extension_result,
    input  logic [NB-1:0]        i_pc_plus4,
    output logic                 o_valid,
    output logic [NB_FCODE-1:0]  o_instruction_funct_code,
    output logic [NB_OPCODE-1:0] o_instruction_op_code,
    output logic                 o_alu_src,
    output logic [NB_CTRL-1:0]   o_ctrl,
    output logic [NB_REG-1:0]    o_rs,
    output logic [NB_REG-1:0]    o_rt,
    output logic [NB_REG-1:0]    o_rd,
    output logic [NB-1:0]        o_data_a,
    output logic [NB-1:0]        o_data_b,
    output logic [NB-1:0]        o_extension_result,
    output logic [NB-1:0]        o_pc_plus4,
    output logic                 o_load_use_hazard,
    output logic [NB_CNT-1:0]    o_stall_count,
    output logic [NB_CNT-1:0]    o_bubble_count
);

    localparam logic [NB_CNT-1:0] CNT_MAX = {NB_CNT{1'b1}};

    // Event qualifiers. A flush always wins over a stall, so a stall only
    // counts when no flush is present on the same edge.
    logic stallEvent;
    logic bubbleEvent;

    always_comb begin
        bubbleEvent = i_step & i_flush;
        stallEvent  = i_step & i_stall & ~i_flush;
    end

    // Pipeline register, updated on the falling edge so that EX sees stable
    // values for the whole high phase. A frozen step holds everything, a
    // flush inserts an all-zero bubble, a stall holds, otherwise load.
    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid                  <= 1'b0;
            o_instruction_funct_code <= '0;
            o_instruction_op_code    <= '0;
            o_alu_src                <= 1'b0;
            o_ctrl                   <= '0;
            o_rs                     <= '0;
            o_rt                     <= '0;
            o_rd                     <= '0;
            o_data_a                 <= '0;
            o_data_b                 <= '0;
            o_extension_result       <= '0;
            o_pc_plus4               <= '0;
        end else if (bubbleEvent) begin
            o_valid                  <= 1'b0;
            o_instruction_funct_code <= '0;
            o_instruction_op_code    <= '0;
            o_alu_src                <= 1'b0;
            o_ctrl                   <= '0;
            o_rs                     <= '0;
            o_rt                     <= '0;
            o_rd                     <= '0;
            o_data_a                 <= '0;
            o_data_b                 <= '0;
            o_extension_result       <= '0;
            o_pc_plus4               <= '0;
        end else if (i_step && !i_stall) begin
            o_valid                  <= i_valid;
            o_instruction_funct_code <= i_instruction_funct_code;
            o_instruction_op_code    <= i_instruction_op_code;
            o_alu_src                <= i_alu_src;
            o_ctrl                   <= i_ctrl;
            o_rs                     <= i_rs;
            o_rt                     <= i_rt;
            o_rd                     <= i_rd;
            o_data_a                 <= i_data_a;
            o_data_b                 <= i_data_b;
            o_extension_result       <= i_extension_result;
            o_pc_plus4               <= i_pc_plus4;
        end
    end

    // Debug counters. A clear beats any increment on the same edge, and each
    // counter sticks at its maximum instead of wrapping so long stalls stay
    // visible. Nothing moves while the pipeline is frozen.
    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_stall_count  <= '0;
            o_bubble_count <= '0;
        end else if (i_step) begin
            if (i_clear_counters) begin
                o_stall_count  <= '0;
                o_bubble_count <= '0;
            end else begin
                if (stallEvent && (o_stall_count != CNT_MAX)) begin
                    o_stall_count <= o_stall_count + 1'b1;
                end
                if (bubbleEvent && (o_bubble_count != CNT_MAX)) begin
                    o_bubble_count <= o_bubble_count + 1'b1;
                end
            end
        end
    end

    // Load-use detection: EX holds a real load writing a non-zero rt that
    // decode wants to read. Purely combinational so the hazard unit can
    // react in the same cycle the decode addresses appear.
    always_comb begin
        o_load_use_hazard = o_valid
                          & o_ctrl[CTRL_MEM_READ_BIT]
                          & (o_rt != '0)
                          & ((o_rt == i_rs) | (o_rt == i_rt));
    end

endmodule
